// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types and defaults for the NoC packet arbiter
package noc_pkg;

  localparam int NOC_FLIT_WIDTH = 32;
  localparam int NOC_INPUTS     = 5;

  typedef logic [NOC_FLIT_WIDTH-1:0] flit_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/noc_packet_arbiter_if.sv
// rtl/noc_packet_arbiter_if.sv - flit request streams and shared output link
interface noc_packet_arbiter_if
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter int INPUTS     = NOC_INPUTS
);

  logic [INPUTS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [INPUTS-1:0]                 in_last;
  logic [INPUTS-1:0]                 in_valid;
  logic [INPUTS-1:0]                 in_ready;
  logic [FLIT_WIDTH-1:0]             out_flit;
  logic                              out_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [INPUTS-1:0]                 grant;
  logic                              busy;

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid, grant, busy
  );

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid, grant, busy
  );

endinterface

// File: rtl/noc_rr_select.sv
// rtl/noc_rr_select.sv - rotate-priority search starting at ptr, wrapping modulo INPUTS
module noc_rr_select #(
  parameter int INPUTS = 5,
  localparam int PW    = $clog2(INPUTS)
) (
  input  logic [INPUTS-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [INPUTS-1:0] gnt,
  output logic [PW-1:0]     gnt_idx,
  output logic              any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = 0; i < INPUTS; i++) begin
      // Explicit wrap keeps non-power-of-2 INPUTS correct.
      idx = int'(ptr) + i;
      if (idx >= INPUTS) idx = idx - INPUTS;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// rtl/noc_packet_arbiter.sv - packet-atomic round-robin arbiter with registered output link
module noc_packet_arbiter
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter int INPUTS     = NOC_INPUTS,
  localparam int PW        = $clog2(INPUTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_packet_arbiter_if.slave  bus
);

  arb_state_t            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         lock_idx_q, lock_idx_d;
  logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;

  logic [INPUTS-1:0]     rr_gnt;
  logic [PW-1:0]         rr_idx;
  logic                  rr_any;
  logic [PW-1:0]         sel_idx;
  logic                  sel_any;
  logic [INPUTS-1:0]     sel_onehot;
  logic                  can_load;
  logic                  xfer;
  logic                  sel_last;

  noc_rr_select #(.INPUTS(INPUTS)) u_rr_select (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_idx_d  = lock_idx_q;
    out_flit_d  = out_flit_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    can_load = !out_valid_q || bus.out_ready;
    if (state_q == ARB_LOCKED) begin
      sel_idx = lock_idx_q;
      sel_any = 1'b1;
    end else begin
      sel_idx = rr_idx;
      sel_any = rr_any;
    end
    sel_onehot = INPUTS'(1) << sel_idx;
    sel_last   = bus.in_last[sel_idx];
    xfer       = rst && sel_any && bus.in_valid[sel_idx] && can_load;

    if (xfer) begin
      out_flit_d  = bus.in_flit[sel_idx];
      out_last_d  = sel_last;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (xfer && !sel_last) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = sel_idx;
        end
      end
      ARB_LOCKED: begin
        if (xfer && sel_last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Pointer only advances when a packet completes, so grants rotate per packet.
    if (xfer && sel_last) begin
      ptr_d = (sel_idx == PW'(INPUTS - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      lock_idx_q  <= '0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.grant     = !rst ? '0 :
                         (state_q == ARB_LOCKED) ? sel_onehot : rr_gnt;
  assign bus.in_ready  = (rst && sel_any && can_load) ? sel_onehot : '0;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ARB_LOCKED);

endmodule

// File: doc/noc_packet_arbiter.md
# noc_packet_arbiter

Packet-atomic round-robin arbiter sharing one NoC output link among `INPUTS` flit streams. One instance per router output port per channel; sits between the per-port input buffers and the output link of the mesh router. Holds a grant from the first flit to the `last` flit, so packets are never interleaved. Drives the link from a single output register stage.

## Interface
- `FLIT_WIDTH`, 32, flit payload width
- `INPUTS`, 5, number of requesting streams (local + N/E/S/W); ≥2
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (asserted when 0)
- `in_flit`  in  INPUTS×FLIT_WIDTH  flit per requester
- `in_last`  in  INPUTS  flit is last of its packet
- `in_valid`  in  INPUTS  requester has a flit
- `in_ready`  out  INPUTS  flit accepted this cycle when valid&ready
- `out_flit`  out  FLIT_WIDTH  registered output flit
- `out_last`  out  1  registered last marker
- `out_valid`  out  1  output register holds a flit
- `out_ready`  in  1  downstream accepts
- `grant`  out  INPUTS  one-hot current/locked grant, 0 when none
- `busy`  out  1  state is LOCKED

## Operation
- FSM states: IDLE (no packet in progress), LOCKED (packet of input `g` in progress).
- `can_load = !out_valid || out_ready`.
- IDLE: `g` = first input with `in_valid` set, searching from `ptr` upward, wrapping modulo INPUTS. `grant` = onehot(g) combinationally; 0 when no valid. `in_ready[g] = can_load`; all other `in_ready` are 0.
  - Transfer with `in_last=1` (single-flit packet): stay IDLE, `ptr <= (g+1) mod INPUTS`.
  - Transfer with `in_last=0`: go LOCKED, register `g`.
  - No transfer (`can_load=0`): stay IDLE. Arbitration is re-evaluated next cycle and may pick a different input.
- LOCKED: `grant` = onehot(locked g); `in_ready[g] = can_load`, all others 0. `in_valid[g]` dropping mid-packet holds the lock (bubble).
  - Transfer with `in_last=1`: go IDLE, `ptr <= (g+1) mod INPUTS`.
- Output register:
  - On a transfer: load `out_flit/out_last` from input `g` and set `out_valid=1`.
  - Else if `out_ready`: clear `out_valid`.
  - `out_flit/out_last` hold their value while `out_valid && !out_ready`.
- Throughput: one flit per cycle when downstream is always ready, including back-to-back packets from different inputs. The cycle following a `last` arbitrates again with no bubble.
- `ptr` width is `$clog2(INPUTS)`. Wrap from INPUTS-1 to 0 is explicit, so non-power-of-2 INPUTS works.

## Timing
- Reset (rst=0 at a clock edge):
  - Outputs: `out_valid=0`, `out_flit=0`, `out_last=0`.
  - State: IDLE, `ptr=0`.
  - `in_ready` and `grant` forced 0 while rst=0.
- Reset mid-packet: lock and the buffered flit are discarded; the remainder of the packet is the requester's responsibility.
- Latency: input flit accepted in cycle n appears on `out_*` in cycle n+1.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid`, state and `ptr`. It does not depend on `in_flit` or `in_last`.
- Once `out_valid=1` it stays 1 until `out_ready=1` (AXI-style rule); `out_flit` stable meanwhile.
- Simultaneous events:
  - Output drains and a new flit loads in the same cycle: legal, `out_valid` stays 1.
  - `last` transfer and new request in the same cycle: new grant takes effect the next cycle.

## Structure
- Package `noc_pkg`: `flit_t` (FLIT_WIDTH logic vector), FSM enum `arb_state_t {ARB_IDLE, ARB_LOCKED}`.
- Sub-module `noc_rr_select`: combinational rotate-priority search (`req[INPUTS]`, `ptr` → one-hot `gnt`, index `gnt_idx`, `any`). Reused by other router arbiters.
- Top holds the FSM, `ptr`, locked index and the output register.

## Test plan
- Reset: hold rst=0 three cycles with all `in_valid=1` → `in_ready=0`, `grant=0`, `out_valid=0`. After release, first grant goes to input 0.
- Fairness: INPUTS=5, all inputs send single-flit packets continuously with `out_ready=1` → output source order 0,1,2,3,4,0…, one flit per cycle.
- Packet atomicity: input 1 sends 4 flits 0xA0..0xA3 (last on 0xA3) while input 2 is valid → output A0,A1,A2,A3, then input 2's flit. `grant` is 0b00010 during the packet.
- Backpressure: `out_ready=0` for 3 cycles mid-packet → `out_flit` stable, `in_ready=0`, no flit lost or duplicated after release.
- Mid-packet bubble: locked input 3 drops `in_valid` for 2 cycles while input 0 is valid → input 0 stays un-ready, `busy=1`; input 3 resumes and completes.
- Reset mid-packet: assert rst after the 2nd of 4 flits → `out_valid=0`, `busy=0`. Next arbitration starts from `ptr=0`.
